viterbi_ber_checker: RTL
========================

// Module: viterbi_ber_checker
// PURPOSE
//  Receive-side checker for the encoder -> channel -> Viterbi decoder loop.
//  - Compares the decoded bit stream against the original source bits.
//  - Finds the unknown pipeline latency automatically, then locks to it.
//  - While locked, counts compared bits and bit errors, so the bench and top level
//    can report post-decode BER against the injected channel error rate.
// PARAMETERS
//  MAX_LAT   64  depth of source-bit history; latencies searched 0..MAX_LAT-1
//  WIN       32  valid samples per evaluation window
//  LOCK_THR   2  max mismatches in a SEARCH window that still declares lock
//  LOSS_THR   8  mismatches in a LOCKED window above which lock is lost
//  CW        32  width of bit/error counters
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         reset, asynchronous, active-low
//  valid_i      in   1         one source bit and one decoded bit are present this cycle
//  ref_bit_i    in   1         source bit (encoder input)
//  dec_bit_i    in   1         decoder output bit
//  clr_i        in   1         synchronous clear of the statistics counters
//  locked_o     out  1         1 = state LOCKED
//  state_o      out  2         00 FILL, 01 SEARCH, 10 LOCKED
//  latency_o    out  LW        current candidate/locked latency; LW=$clog2(MAX_LAT)
//  bit_count_o  out  CW        bits compared while LOCKED; saturates at all-ones
//  err_count_o  out  CW        mismatches while LOCKED; saturates at all-ones
//  err_o        out  1         1-cycle pulse, cycle after a LOCKED mismatch
//  max_burst_o  out  8         longest run of consecutive LOCKED errors (macro only)
// BEHAVIOUR
//  - Reset (rst=0): every output 0, history all 0, state FILL, L=0.
//    Reset mid-operation aborts everything; no state is retained.
//  - History: on valid_i, hist <= {hist[MAX_LAT-2:0], ref_bit_i}.
//    The compare uses the pre-shift value: cand = (L==0) ? ref_bit_i : hist[L-1].
//    mis = valid_i & (dec_bit_i ^ cand).
//  - Cycles with valid_i=0 are ignored completely: no shift, no count, no window advance.
//  - FILL: count valid samples; after MAX_LAT samples -> SEARCH, window cleared.
//  - SEARCH, per window of WIN valid samples (w = 0..WIN-1, m = mismatch tally):
//    - On the last sample, evaluate m+mis.
//    - If <= LOCK_THR -> LOCKED; latency_o holds L.
//    - Otherwise L <= (L==MAX_LAT-1) ? 0 : L+1 (wrap-around), and a new window starts.
//    - Statistics counters do not move in SEARCH.
//  - LOCKED, per valid sample:
//    - bit_count_o += 1.
//    - If mis: err_count_o += 1, err_o=1 on the next cycle.
//    - Window tally as in SEARCH. On the last sample, if m+mis > LOSS_THR -> SEARCH,
//      keeping the same L so the current latency is retried first. Counters hold.
//  - Outputs are registered; locked_o/state_o change the cycle after the deciding sample.
//  - clr_i=1: bit_count_o and err_count_o <= 0, and max_burst_o <= 0.
//    - Has priority over a same-cycle increment; that sample is not counted.
//    - Does not affect state, L, history or the window tally.
//  - Both counters saturate at 2**CW-1 and never wrap.
// CONFIGURATION
//  `define VITERBI_BER_BURST_EN
//   - Defined: track run = consecutive LOCKED valid samples with mis=1.
//     A clean valid sample resets run to 0.
//     max_burst_o <= max(max_burst_o, run); saturates at 255.
//   - Not defined: no burst logic is built; max_burst_o is tied to 0.
// TESTING
//  1 Assert rst=0 mid-stream -> all outputs 0 and state_o=00 immediately (async).
//  2 PRBS7 ref with dec = ref delayed 37 valid samples, no errors
//    -> state_o=10, latency_o=37 after 64+38*32=1280 valid samples; err_count_o=0.
//  3 Locked at L=37, flip every 8th dec bit, 256 bits
//    -> stays locked, err_count_o=32, bit_count_o=256, 32 err_o pulses.
//  4 Locked, flip 12 bits inside one window
//    -> locked_o=0 after that window; relock at L=37 after one clean window;
//       counters held at their values across the SEARCH interval.
//  5 clr_i on the same cycle as a mismatch -> err_count_o=0, bit_count_o=0 next cycle;
//    locked_o unchanged.
//  6 Macro defined: bursts of 3 then 5 consecutive errors (each <= LOSS_THR)
//    -> max_burst_o=5. Macro undefined: max_burst_o=0.
//  Also: valid_i toggling 50% duty gives results identical to case 2 in valid-sample units.

Source files
------------

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
//   Receive-side checker for an encoder -> channel -> Viterbi decoder loop.
//   It keeps a history of source bits, searches for the decoder pipeline
//   latency by testing one candidate latency per window, locks once a window
//   is clean enough, and then counts compared bits and bit errors.
//
//   Optional feature: define VITERBI_BER_BURST_EN to build the longest
//   consecutive-error burst tracker; otherwise max_burst_o is tied to 0.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   valid_i      a source bit and a decoded bit are present this cycle
//   ref_bit_i    source bit (encoder input)
//   dec_bit_i    decoder output bit
//   clr_i        synchronous clear of bit/error counters and max burst
//   locked_o     1 while LOCKED
//   state_o      00 FILL, 01 SEARCH, 10 LOCKED
//   latency_o    current candidate / locked latency
//   bit_count_o  bits compared while LOCKED (saturating)
//   err_count_o  mismatches while LOCKED (saturating)
//   err_o        one-cycle pulse after a LOCKED mismatch
//   max_burst_o  longest run of consecutive LOCKED errors

module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int WIN      = 32,
  parameter int LOCK_THR = 2,
  parameter int LOSS_THR = 8,
  parameter int CW       = 32,
  localparam int LW      = $clog2(MAX_LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic          ref_bit_i,
  input  logic          dec_bit_i,
  input  logic          clr_i,
  output logic          locked_o,
  output logic [1:0]    state_o,
  output logic [LW-1:0] latency_o,
  output logic [CW-1:0] bit_count_o,
  output logic [CW-1:0] err_count_o,
  output logic          err_o,
  output logic [7:0]    max_burst_o
);

  // state  | meaning
  // FILL   | loading the source history, no compares yet
  // SEARCH | testing latency_o for one window, stepping on failure
  // LOCKED | latency found, statistics counting

  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int MW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'b00,
    S_SEARCH = 2'b01,
    S_LOCKED = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [MAX_LAT-1:0] hist;
  logic [LW-1:0]     fill_cnt;
  logic [WW-1:0]     win_cnt;
  logic [MW-1:0]     mis_cnt;
  logic [LW-1:0]     lat;
  logic              cand;
  logic              mis;
  logic              last_smp;
  logic [MW-1:0]     tally;
  logic              lock_ok;
  logic              lock_lost;

  // Compare against the history before this sample's shift; latency 0 means
  // the decoded bit lines up with the source bit presented in the same cycle.
  assign cand      = (lat == '0) ? ref_bit_i : hist[lat - LW'(1)];
  assign mis       = valid_i & (dec_bit_i ^ cand);
  assign last_smp  = valid_i && (win_cnt == WW'(WIN - 1));
  assign tally     = mis_cnt + MW'(mis);
  assign lock_ok   = (tally <= MW'(LOCK_THR));
  assign lock_lost = (tally > MW'(LOSS_THR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:   if (valid_i && (fill_cnt == LW'(MAX_LAT - 1))) state_nxt = S_SEARCH;
      S_SEARCH: if (last_smp && lock_ok) state_nxt = S_LOCKED;
      S_LOCKED: if (last_smp && lock_lost) state_nxt = S_SEARCH;
      default:  state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    locked_o = (state == S_LOCKED);
    state_o  = state;
  end

  assign latency_o = lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= '0;
      fill_cnt <= '0;
      win_cnt  <= '0;
      mis_cnt  <= '0;
      lat      <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= mis && (state == S_LOCKED);
      if (valid_i) begin
        hist <= {hist[MAX_LAT-2:0], ref_bit_i};
        if (state == S_FILL) begin
          fill_cnt <= fill_cnt + LW'(1);
          win_cnt  <= '0;
          mis_cnt  <= '0;
        end else if (last_smp) begin
          win_cnt <= '0;
          mis_cnt <= '0;
          // A failed search window moves on to the next latency; a lost lock
          // keeps the current one so it is retried first.
          if ((state == S_SEARCH) && !lock_ok)
            lat <= (lat == LW'(MAX_LAT - 1)) ? '0 : lat + LW'(1);
        end else begin
          win_cnt <= win_cnt + WW'(1);
          mis_cnt <= tally;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_count_o <= '0;
      err_count_o <= '0;
    end else if (clr_i) begin
      bit_count_o <= '0;
      err_count_o <= '0;
    end else if (valid_i && (state == S_LOCKED)) begin
      if (bit_count_o != '1) bit_count_o <= bit_count_o + CW'(1);
      if (mis && (err_count_o != '1)) err_count_o <= err_count_o + CW'(1);
    end
  end

`ifdef VITERBI_BER_BURST_EN
  logic [7:0] run, run_nxt, max_burst;

  // Any valid sample that is not a LOCKED mismatch breaks the run.
  always_comb begin
    run_nxt = run;
    if (valid_i) begin
      if (mis && (state == S_LOCKED)) run_nxt = (run == 8'hFF) ? run : run + 8'd1;
      else                            run_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 8'd0;
      max_burst <= 8'd0;
    end else begin
      run <= run_nxt;
      if (clr_i)
        max_burst <= 8'd0;
      else if (valid_i && (state == S_LOCKED) && (run_nxt > max_burst))
        max_burst <= run_nxt;
    end
  end

  assign max_burst_o = max_burst;
`else
  assign max_burst_o = 8'd0;
`endif

endmodule
